css_mcu0_el2_dccm_sram_sink: RTL
================================

# css_mcu0_el2_dccm_sram_sink

Memory-side responder for the banked DCCM SRAM export of the MCU0 VeeR EL2 core. It terminates the per-bank clock-enable/write-enable/address/data/ECC requests that the core memory wrapper drives and returns registered read data and ECC one cycle later. It also contains a power-on/on-demand initialisation engine that writes zero data with valid ECC to every entry, so the core never reads uninitialised ECC. It sits in the subsystem top, directly on the sink side of the core's SRAM export interface.

## Interface
- NUM_BANKS, 4, DCCM bank count (power of two, 2..8)
- INDEX_W, 10, per-bank address width; depth = 2**INDEX_W
- DATA_W, 32, data bits per bank entry
- ECC_W, 7, ECC bits per bank entry
- clk  in  1  core clock; the only clock
- rst_l  in  1  reset; asynchronous, active-low
- dccm_clken  in  NUM_BANKS  per-bank access enable
- dccm_wren_bank  in  NUM_BANKS  per-bank write (valid only with clken)
- dccm_addr_bank  in  NUM_BANKS x INDEX_W  per-bank entry index
- dccm_wr_data_bank  in  NUM_BANKS x DATA_W  write data
- dccm_wr_ecc_bank  in  NUM_BANKS x ECC_W  write ECC
- dccm_bank_dout  out  NUM_BANKS x DATA_W  read data
- dccm_bank_ecc  out  NUM_BANKS x ECC_W  read ECC
- init_req  in  1  pulse: re-run initialisation
- init_done  out  1  high when no initialisation is pending or running
- err_inj_req / err_inj_bank / err_inj_bit  in  1 / log2(NUM_BANKS) / 6  error-injection arm (macro only)
- err_inj_done  out  1  one-cycle pulse when an armed injection is consumed (macro only)

## Operation
- Per bank, each cycle: clken & wren -> write {ecc,data} at addr; clken & !wren -> read; !clken -> idle. Banks are independent.
- Read data/ECC registered: appears on dout/ecc the cycle after the read; holds until the next read of that bank. Writes do not update dout.
- Write then read of the same entry in consecutive cycles returns the new value.
- Init FSM states: INIT, DONE. Reset enters INIT with counter 0. In INIT, each cycle with no bank clken asserted: write data 0 / ECC 0 to entry counter in all banks, counter++. Any clken asserted: core access proceeds, init stalls that cycle (counter holds). Counter = depth-1 written -> DONE.
- DONE: init_req -> INIT, counter 0. init_req in INIT is ignored (no restart).
- init_done = (state == DONE). Reads during INIT return stored content (unspecified for unwritten entries).
- Reset mid-init restarts from entry 0; storage is not reset.

## Timing
- Reset values: dccm_bank_dout 0, dccm_bank_ecc 0, init_done 0, err_inj_done 0.
- Read latency 1 cycle; write takes effect at the clock edge it is presented.
- Full init from reset, no core traffic: init_done rises at cycle 2**INDEX_W after rst_l deassert (1024 for defaults).
- Each stalled cycle delays init_done by exactly one cycle.

## Configuration
- CSS_MCU0_DCCM_ERR_INJ_EN defined: err_inj_req latches bank/bit (bit 0..DATA_W-1 data, DATA_W..DATA_W+ECC_W-1 ECC; larger values ignored). The next read of that bank returns the bit inverted (storage untouched), the armed state clears, and err_inj_done pulses in the cycle the corrupted data is presented. A new err_inj_req while armed overwrites the armed bank/bit.
- Not defined: err_inj_* inputs unused, err_inj_done tied 0, no injection logic.

## Structure
- Shared package: init FSM state enum, ECC-of-zero constant (7'h00), error-injection packet struct {bank, bit}.
- One sub-module: css_mcu0_el2_dccm_sram_bank (single-port, INDEX_W x (DATA_W+ECC_W) array with registered read), instantiated NUM_BANKS times; top holds the init FSM, arbitration and injection.

## Test plan
- Reset, no traffic -> init_done low for 1024 cycles, high at cycle 1024; read bank 2 entry 0x3FF -> dout 0, ecc 0 next cycle.
- After init: write bank 1 addr 0x005 data 0xDEADBEEF ecc 0x5A, read next cycle -> dout[1] 0xDEADBEEF, ecc[1] 0x5A one cycle later; other banks' dout unchanged.
- During init, assert clken on bank 0 for 10 cycles -> init_done delayed exactly 10 cycles; a write issued at counter 0x100 survives only if its address is below the counter at the time of the write.
- Write 0xA5A5A5A5 to bank 3 addr 7, init_req -> init_done drops next cycle, rises 1024 cycles later; read bank 3 addr 7 -> 0.
- Macro defined: arm bank 0 bit 4, read bank 0 entry holding 0x0 -> dout 0x10, err_inj_done pulse; reread -> 0x0, no pulse. Bit 35 -> ecc bit 3 flipped.
- Assert rst_l low at counter 0x200 -> init_done 0, dout 0; init restarts, init_done at cycle 1024 after release.

Source files
------------

// File: rtl/css_mcu0_el2_dccm_sram_sink_pkg.sv
// Shared types and constants for the MCU0 EL2 DCCM SRAM sink.
package css_mcu0_el2_dccm_sram_sink_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    DONE = 1'b1
  } init_state_e;

  localparam logic [6:0] ECC_ZERO = 7'h00;

  // Bank field sized for the largest supported bank count (8).
  typedef struct packed {
    logic [2:0] bank;
    logic [5:0] bit_idx;
  } err_inj_pkt_t;

endpackage

// File: rtl/css_mcu0_el2_dccm_sram_sink_if.sv
// Banked DCCM SRAM request/response bundle between the core wrapper and the sink.
interface css_mcu0_el2_dccm_sram_sink_if #(
  parameter int NUM_BANKS = 4,
  parameter int INDEX_W   = 10,
  parameter int DATA_W    = 32,
  parameter int ECC_W     = 7
);

  logic [NUM_BANKS-1:0]              dccm_clken;
  logic [NUM_BANKS-1:0]              dccm_wren_bank;
  logic [NUM_BANKS-1:0][INDEX_W-1:0] dccm_addr_bank;
  logic [NUM_BANKS-1:0][DATA_W-1:0]  dccm_wr_data_bank;
  logic [NUM_BANKS-1:0][ECC_W-1:0]   dccm_wr_ecc_bank;
  logic [NUM_BANKS-1:0][DATA_W-1:0]  dccm_bank_dout;
  logic [NUM_BANKS-1:0][ECC_W-1:0]   dccm_bank_ecc;

  modport master (
    output dccm_clken, dccm_wren_bank, dccm_addr_bank, dccm_wr_data_bank, dccm_wr_ecc_bank,
    input  dccm_bank_dout, dccm_bank_ecc
  );

  modport slave (
    input  dccm_clken, dccm_wren_bank, dccm_addr_bank, dccm_wr_data_bank, dccm_wr_ecc_bank,
    output dccm_bank_dout, dccm_bank_ecc
  );

endinterface

// File: rtl/css_mcu0_el2_dccm_sram_sink_bank.sv
// Single-port DCCM bank: {ecc,data} array with a registered read port.
module css_mcu0_el2_dccm_sram_bank #(
  parameter int INDEX_W = 10,
  parameter int WIDTH   = 39
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic               en,
  input  logic               we,
  input  logic [INDEX_W-1:0] addr,
  input  logic [WIDTH-1:0]   wdata,
  output logic [WIDTH-1:0]   rdata
);

  logic [WIDTH-1:0] mem [2**INDEX_W];

  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
  end

  // Read register holds its value across writes and idle cycles.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)          rdata <= '0;
    else if (en && !we)  rdata <= mem[addr];
  end

endmodule

// File: rtl/css_mcu0_el2_dccm_sram_sink.sv
// DCCM SRAM sink: per-bank memories, zero-fill init engine, optional read error
// injection enabled by the CSS_MCU0_DCCM_ERR_INJ_EN macro.
module css_mcu0_el2_dccm_sram_sink
  import css_mcu0_el2_dccm_sram_sink_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int INDEX_W   = 10,
  parameter int DATA_W    = 32,
  parameter int ECC_W     = 7
) (
  input  logic                         clk,
  input  logic                         rst_l,
  css_mcu0_el2_dccm_sram_sink_if.slave dccm,
  input  logic                         init_req,
  output logic                         init_done,
  input  logic                         err_inj_req,
  input  logic [$clog2(NUM_BANKS)-1:0] err_inj_bank,
  input  logic [5:0]                   err_inj_bit,
  output logic                         err_inj_done
);

  localparam int WIDTH = DATA_W + ECC_W;
  localparam logic [0:0] ST_INIT = INIT;
  localparam logic [0:0] ST_DONE = DONE;

  logic [0:0]           state;
  logic [INDEX_W-1:0]   init_cnt;
  logic                 init_wr;
  logic [NUM_BANKS-1:0] read_en;
  logic [NUM_BANKS-1:0] consume;

  // Init only owns the banks in cycles where the core touches none of them.
  assign init_wr   = (state == ST_INIT) && !(|dccm.dccm_clken);
  assign read_en   = dccm.dccm_clken & ~dccm.dccm_wren_bank;
  assign init_done = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else if (state == ST_INIT) begin
      if (init_wr) begin
        init_cnt <= init_cnt + 1'b1;
        if (&init_cnt) state <= ST_DONE;
      end
    end else if (init_req) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end
  end

`ifdef CSS_MCU0_DCCM_ERR_INJ_EN
  err_inj_pkt_t armed_pkt;
  logic         armed;
  logic         done_q;
  logic         req_ok;

  assign req_ok = err_inj_req && (int'(err_inj_bit) < WIDTH);

  // A fresh request re-arms even in the cycle an older arm is consumed.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      armed     <= 1'b0;
      armed_pkt <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= |consume;
      if (req_ok) begin
        armed     <= 1'b1;
        armed_pkt <= '{bank: 3'(err_inj_bank), bit_idx: err_inj_bit};
      end else if (|consume) begin
        armed <= 1'b0;
      end
    end
  end

  assign err_inj_done = done_q;
`else
  logic unused_err_inj;
  assign unused_err_inj = ^{err_inj_req, err_inj_bank, err_inj_bit};
  assign consume        = '0;
  assign err_inj_done   = 1'b0;
`endif

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic               en;
    logic               we;
    logic [INDEX_W-1:0] addr;
    logic [WIDTH-1:0]   wdata;
    logic [WIDTH-1:0]   rdata;
    logic [WIDTH-1:0]   rdata_out;

    assign en    = init_wr | dccm.dccm_clken[b];
    assign we    = init_wr | dccm.dccm_wren_bank[b];
    assign addr  = init_wr ? init_cnt : dccm.dccm_addr_bank[b];
    assign wdata = init_wr ? {ECC_W'(ECC_ZERO), {DATA_W{1'b0}}}
                           : {dccm.dccm_wr_ecc_bank[b], dccm.dccm_wr_data_bank[b]};

    css_mcu0_el2_dccm_sram_bank #(
      .INDEX_W (INDEX_W),
      .WIDTH   (WIDTH)
    ) u_bank (
      .clk   (clk),
      .rst_l (rst_l),
      .en    (en),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata)
    );

`ifdef CSS_MCU0_DCCM_ERR_INJ_EN
    logic [WIDTH-1:0] flip_q;

    assign consume[b] = armed && (armed_pkt.bank == 3'(b)) && read_en[b];

    // The flip mask follows the read register so corruption holds until the next read.
    always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l)          flip_q <= '0;
      else if (read_en[b]) flip_q <= consume[b] ? (WIDTH'(1) << armed_pkt.bit_idx) : '0;
    end

    assign rdata_out = rdata ^ flip_q;
`else
    logic unused_read_en;
    assign unused_read_en = read_en[b];
    assign rdata_out      = rdata;
`endif

    assign dccm.dccm_bank_dout[b] = rdata_out[DATA_W-1:0];
    assign dccm.dccm_bank_ecc[b]  = rdata_out[WIDTH-1:DATA_W];
  end

endmodule
